pwm_sample_feeder: RTL and testbench

- Upstream stage of the PWM generator.
- Accepts 8-bit audio samples from a producer (BRAM/ROM reader) over a valid/ready handshake and buffers them in a small FIFO.
- Drives the PWM duty input, updating it exactly once per PWM period so the comparator never sees a mid-period change.
- Handles start-up priming, underrun and disable cleanly.

---
 rtl/pwm_sample_feeder.sv | 172 +++++++++++++++++
 tb/tb_pwm_sample_feeder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_sample_feeder.sv
// -----------------------------------------------------------------------------
// pwm_sample_feeder
//
// Upstream stage of the PWM generator. Buffers 8-bit audio samples from a
// producer in a small FIFO and updates the PWM duty exactly once per PWM
// period, so the comparator never sees a duty change in mid-period.
//
// Handshake (s_valid/s_ready): a sample is transferred on every rising clk
// edge where s_valid && s_ready are both high. The producer holds s_data and
// s_valid stable until that transfer happens. s_ready never depends on
// s_valid.
//
// Optional feature (macro PWM_FEEDER_UNDERRUN_CNT_EN): adds a 16-bit
// saturating underrun counter output, cleared while enable is low.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       playback enable
//   s_data       sample from producer
//   s_valid      s_data valid
//   s_ready      feeder can accept a sample
//   pwm_in       registered duty to the PWM block
//   period_tick  one-cycle pulse on the last cycle of each PWM period
//   underrun     one-cycle pulse when a period boundary finds the FIFO empty
//                during playback
//   fifo_level   current FIFO occupancy, 0..2^FIFO_AW
//   underrun_cnt saturating underrun count (macro builds only)
//   dbg_state    FSM state: 0 = IDLE, 1 = FILL, 2 = PLAY
// -----------------------------------------------------------------------------
module pwm_sample_feeder #(
  parameter int          PERIOD_BITS = 17,
  parameter int          FIFO_AW     = 4,
  parameter int          PRIME_LEVEL = 8,
  parameter logic [7:0]  IDLE_LEVEL  = 8'h80
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [7:0]         pwm_in,
  output logic               period_tick,
  output logic               underrun,
  output logic [FIFO_AW:0]   fifo_level,
`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
  output logic [15:0]        underrun_cnt,
`endif
  output logic [1:0]         dbg_state
);

  localparam int               DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PRIME_LVL = (FIFO_AW+1)'(PRIME_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [PERIOD_BITS-1:0] cnt_q;
  logic [FIFO_AW:0]       wr_ptr_q, rd_ptr_q;
  logic [7:0]             mem_q [DEPTH];
  logic [7:0]             pwm_q, pwm_d;
  logic                   fifo_empty, fifo_full;
  logic                   push, pop;
  logic                   underrun_d;

  // Period counter free-runs regardless of state so it stays locked to the
  // PWM block's own counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_q + 1'b1;
  end

  assign period_tick = &cnt_q;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // low bits with differing wrap bits mean full.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign fifo_level = wr_ptr_q - rd_ptr_q;

  // Not ready in IDLE, which also keeps s_ready low straight out of reset
  // whatever enable is doing.
  assign s_ready = enable && (state_q != ST_IDLE) && !fifo_full;
  assign push    = s_valid && s_ready;

  always_comb begin
    state_d    = state_q;
    pwm_d      = pwm_q;
    pop        = 1'b0;
    underrun_d = 1'b0;
    if (!enable) begin
      // Disable wins from any state; the duty only drops to silence on a
      // period boundary.
      state_d = ST_IDLE;
      if (period_tick) pwm_d = IDLE_LEVEL;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_FILL;
          if (period_tick) pwm_d = IDLE_LEVEL;
        end
        ST_FILL: begin
          if (period_tick && (fifo_level >= PRIME_LVL)) begin
            state_d = ST_PLAY;
            pop     = 1'b1;
          end
        end
        ST_PLAY: begin
          if (period_tick) begin
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              underrun_d = 1'b1;
              state_d    = ST_FILL;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Sample is captured on the tick cycle and shows up as counter wraps to 0.
    if (pop) pwm_d = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  end

  assign underrun = underrun_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pwm_q    <= IDLE_LEVEL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      pwm_q   <= pwm_d;
      if (!enable) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset; occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= s_data;
  end

  assign pwm_in    = pwm_q;
  assign dbg_state = state_q;

`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] ur_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ur_cnt_q <= '0;
    else if (!enable)                    ur_cnt_q <= '0;
    else if (underrun_d && !(&ur_cnt_q)) ur_cnt_q <= ur_cnt_q + 1'b1;
  end

  assign underrun_cnt = ur_cnt_q;
`endif

endmodule

// File: tb/tb_pwm_sample_feeder.sv
module tb_pwm_sample_feeder;

  localparam int PB = 4;   // 16-cycle PWM period
  localparam int AW = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic [7:0]    pwm_in;
  logic          period_tick;
  logic          underrun;
  logic [AW:0]   fifo_level;
  logic [1:0]    dbg_state;
`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
  logic [15:0]   underrun_cnt;
`endif

  always #5 clk = ~clk;

  pwm_sample_feeder #(
    .PERIOD_BITS (PB),
    .FIFO_AW     (AW),
    .PRIME_LEVEL (8),
    .IDLE_LEVEL  (8'h80)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .pwm_in      (pwm_in),
    .period_tick (period_tick),
    .underrun    (underrun),
    .fifo_level  (fifo_level),
`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
    .underrun_cnt(underrun_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         checks   = 0;
  int         failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent model of the period counter position.
  logic [PB-1:0] tb_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= '0;
    else        tb_cnt <= tb_cnt + 1'b1;
  end

  // Continuous monitor: tick position and duty changes only at counter 0.
  logic [7:0] prev_pwm   = 8'h80;
  logic       prev_rst_n = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("tick_pos", {31'd0, period_tick}, {31'd0, (tb_cnt == {PB{1'b1}})});
      if (prev_rst_n && (pwm_in !== prev_pwm))
        chk("pwm_boundary", {28'd0, tb_cnt}, 32'd0);
    end
    prev_pwm   = pwm_in;
    prev_rst_n = rst_n;
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [7:0] d);
    int g = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("push_timeout", {31'd0, (g < 200)}, 32'd1);
    if (g < 200) exp_q.push_back(d);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Returns at the negedge of the counter-0 cycle following the next tick.
  task automatic wait_tick(input logic exp_ur);
    int g = 0;
    while (period_tick !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("tick_timeout", {31'd0, (g < 100)}, 32'd1);
    chk("underrun_at_tick", {31'd0, underrun}, {31'd0, exp_ur});
    @(negedge clk);
  endtask

  task automatic chk_pop(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {24'd0, pwm_in}, {24'd0, e});
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int ticks;
    int n;
    rst_n   = 1'b0;
    enable  = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_pwm",      {24'd0, pwm_in}, 32'h80);
    chk("rst_ready",    {31'd0, s_ready}, 32'd0);
    chk("rst_tick",     {31'd0, period_tick}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_level",    {27'd0, fifo_level}, 32'd0);
    chk("rst_state",    {30'd0, dbg_state}, 32'd0);
    #1 rst_n = 1'b1;

    // Idle with enable low for 40 cycles: ticks at counts 15 and 31.
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (period_tick) ticks++;
    end
    chk("idle_ticks", ticks, 32'd2);
    chk("idle_pwm",   {24'd0, pwm_in}, 32'h80);
    chk("idle_ready", {31'd0, s_ready}, 32'd0);
    chk("idle_level", {27'd0, fifo_level}, 32'd0);

    // Prime with 1..8 and play them out, one per period.
    enable = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    chk("prime_level", {27'd0, fifo_level}, 32'd8);
    chk("prime_pwm",   {24'd0, pwm_in}, 32'h80);
    for (int i = 0; i < 8; i++) begin
      wait_tick(1'b0);
      chk_pop("play_pwm");
      chk("play_level", {27'd0, fifo_level}, exp_q.size());
    end

    // Next boundary finds the FIFO empty.
    wait_tick(1'b1);
    chk("ur_pulse_end", {31'd0, underrun}, 32'd0);
    chk("ur_pwm_hold",  {24'd0, pwm_in}, 32'h08);
    chk("ur_state",     {30'd0, dbg_state}, 32'd1);
`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
    chk("ur_cnt", {16'd0, underrun_cnt}, 32'd1);
`endif

    // Fill to full without a pop: 7 samples, let a tick pass, then 9 more.
    for (int i = 0; i < 7; i++) push(8'h10 + 8'(i));
    wait_tick(1'b0);
    chk("fill_pwm_hold", {24'd0, pwm_in}, 32'h08);
    for (int i = 7; i < 16; i++) push(8'h10 + 8'(i));
    chk("full_level", {27'd0, fifo_level}, 32'd16);
    chk("full_ready", {31'd0, s_ready}, 32'd0);

    // Hold a sample across the tick pop: 16 -> 15 -> 16.
    s_data  = 8'h20;
    s_valid = 1'b1;
    n = 0;
    while (period_tick !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("full_tick_timeout", {31'd0, (n < 100)}, 32'd1);
    chk("full_tick_level", {27'd0, fifo_level}, 32'd16);
    chk("full_tick_ready", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    chk_pop("full_pop_pwm");
    chk("after_pop_level", {27'd0, fifo_level}, 32'd15);
    chk("after_pop_ready", {31'd0, s_ready}, 32'd1);
    if (s_ready) exp_q.push_back(8'h20);
    @(negedge clk);
    s_valid = 1'b0;
    chk("refill_level", {27'd0, fifo_level}, 32'd16);

    // Play 11 samples, leaving 5 queued.
    for (int i = 0; i < 11; i++) begin
      wait_tick(1'b0);
      chk_pop("play2_pwm");
    end
    chk("pre_dis_level", {27'd0, fifo_level}, 32'd5);

    // Disable mid-period: immediate flush, silence at the next boundary.
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_level", {27'd0, fifo_level}, 32'd0);
    chk("dis_ready", {31'd0, s_ready}, 32'd0);
    chk("dis_state", {30'd0, dbg_state}, 32'd0);
    chk("dis_pwm_hold", {24'd0, pwm_in}, 32'h1B);
    exp_q.delete();
    wait_tick(1'b0);
    chk("dis_pwm_idle", {24'd0, pwm_in}, 32'h80);
`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
    chk("dis_ur_cnt", {16'd0, underrun_cnt}, 32'd0);
`endif

    // Async reset in mid-period during playback.
    enable = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'h30 + 8'(i));
    wait_tick(1'b0);
    chk_pop("rst_play_pwm");
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pwm",   {24'd0, pwm_in}, 32'h80);
    chk("arst_level", {27'd0, fifo_level}, 32'd0);
    chk("arst_ready", {31'd0, s_ready}, 32'd0);
    chk("arst_tick",  {31'd0, period_tick}, 32'd0);
    chk("arst_state", {30'd0, dbg_state}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_tick !== 1'b1 && n < 100);
    chk("arst_restart_tick", n, 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
